// File: rtl/retire_unit.sv
// retire_unit: in-order commit stage.
// Retires a contiguous prefix of the ROB head entries. It frees T_old and
// updates the architectural map with T_new for every retiring slot that has
// a destination. A mispredict or halt ends the retire group for that cycle.
// Optional feature macro: RETIRE_PERF_CNT_EN enables the retired_count
// counter. When the macro is undefined, retired_count is tied to zero.
// Packed ROB entry layout (MSB..LSB), one PKT_W-bit field per slot with the
// oldest entry at slot 0:
//   {complete, has_dest, arch_dest, T_new, T_old, mispredict, halt}

`ifndef N
`define N 3
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

module retire_unit #(
   parameter int N          = `N,
   parameter int PHYS_BITS  = $clog2(`PHYS_REG_SZ),
   parameter int ARCH_BITS  = 5,
   localparam int PKT_W     = 4 + ARCH_BITS + 2 * PHYS_BITS,
   localparam int CNT_W     = $clog2(N + 1)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N*PKT_W-1:0]        rob_outputs,
   input  logic [CNT_W-1:0]          outputs_valid,
   output logic [CNT_W-1:0]          num_retiring,
   output logic [N-1:0]              free_valid,
   output logic [N*PHYS_BITS-1:0]    free_reg,
   output logic [N-1:0]              amt_we,
   output logic [N*ARCH_BITS-1:0]    amt_idx,
   output logic [N*PHYS_BITS-1:0]    amt_reg,
   output logic                      flush,
   output logic                      halted,
   output logic [31:0]               retired_count
);

   // Bit positions inside one packed entry
   localparam int HALT_B   = 0;
   localparam int MISP_B   = 1;
   localparam int TOLD_LSB = 2;
   localparam int TNEW_LSB = 2 + PHYS_BITS;
   localparam int ADST_LSB = 2 + 2 * PHYS_BITS;
   localparam int HDST_B   = PKT_W - 2;
   localparam int CMPL_B   = PKT_W - 1;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FLUSH  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t              state_r;
   state_t              next_state_s;
   logic                flush_r;
   logic                halted_r;
   logic [N-1:0]        complete_s;
   logic [N-1:0]        has_dest_s;
   logic [N-1:0]        mispredict_s;
   logic [N-1:0]        halt_s;
   logic [N-1:0]        retire_s;
   logic [CNT_W-1:0]    count_s;
   logic                open_s;

   // Unpack each slot and drive the free-list / map-table ports
   for (genvar g = 0; g < N; g++) begin : g_slot
      assign complete_s[g]   = rob_outputs[g*PKT_W + CMPL_B];
      assign has_dest_s[g]   = rob_outputs[g*PKT_W + HDST_B];
      assign mispredict_s[g] = rob_outputs[g*PKT_W + MISP_B];
      assign halt_s[g]       = rob_outputs[g*PKT_W + HALT_B];
      assign free_reg[g*PHYS_BITS +: PHYS_BITS] = rob_outputs[g*PKT_W + TOLD_LSB +: PHYS_BITS];
      assign amt_reg[g*PHYS_BITS +: PHYS_BITS]  = rob_outputs[g*PKT_W + TNEW_LSB +: PHYS_BITS];
      assign amt_idx[g*ARCH_BITS +: ARCH_BITS]  = rob_outputs[g*PKT_W + ADST_LSB +: ARCH_BITS];
      assign free_valid[g] = retire_s[g] & has_dest_s[g];
      assign amt_we[g]     = retire_s[g] & has_dest_s[g];
   end

   // Retire-prefix selection and next-state decode; reset forces no retirement
   always_comb begin
      next_state_s = state_r;
      retire_s     = '0;
      count_s      = '0;
      open_s       = 1'b1;
      if (reset) begin
         next_state_s = RUN;
      end else begin
         case (state_r)
            RUN: begin
               for (int i = 0; i < N; i++) begin
                  if (open_s && (CNT_W'(i) < outputs_valid) && complete_s[i]) begin
                     retire_s[i] = 1'b1;
                     count_s     = count_s + CNT_W'(1'b1);
                     // Halt wins over mispredict on the same slot
                     if (halt_s[i]) begin
                        open_s       = 1'b0;
                        next_state_s = HALTED;
                     end else if (mispredict_s[i]) begin
                        open_s       = 1'b0;
                        next_state_s = FLUSH;
                     end else begin
                        open_s       = open_s;
                     end
                  end else begin
                     open_s = 1'b0;
                  end
               end
            end
            FLUSH:   next_state_s = RUN;
            HALTED:  next_state_s = HALTED;
            default: next_state_s = RUN;
         endcase
      end
   end

   assign num_retiring = count_s;

   // State register with registered flush and halted indications
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r  <= RUN;
         flush_r  <= 1'b0;
         halted_r <= 1'b0;
      end else begin
         state_r  <= next_state_s;
         flush_r  <= (next_state_s == FLUSH);
         halted_r <= (next_state_s == HALTED);
      end
   end

   assign flush  = flush_r;
   assign halted = halted_r;

`ifdef RETIRE_PERF_CNT_EN
   logic [31:0] count_r;

   // Committed-instruction counter, wraps modulo 2^32
   always_ff @(posedge clock) begin
      if (reset) begin
         count_r <= 32'd0;
      end else begin
         count_r <= count_r + {{(32-CNT_W){1'b0}}, count_s};
      end
   end

   assign retired_count = count_r;
`else
   assign retired_count = 32'd0;
`endif

endmodule

// File: tb/tb_retire_unit.sv
// tb_retire_unit: directed and random stimulus for retire_unit (N=3) checked
// against a behavioural commit model built from the retirement rules.
module tb_retire_unit;
   localparam int N     = 3;
   localparam int PB    = 6;
   localparam int AB    = 5;
   localparam int PKT_W = 4 + AB + 2 * PB;

   logic                 clock = 1'b0;
   logic                 reset;
   logic [N*PKT_W-1:0]   rob_outputs;
   logic [1:0]           outputs_valid;
   logic [1:0]           num_retiring;
   logic [N-1:0]         free_valid;
   logic [N*PB-1:0]      free_reg;
   logic [N-1:0]         amt_we;
   logic [N*AB-1:0]      amt_idx;
   logic [N*PB-1:0]      amt_reg;
   logic                 flush;
   logic                 halted;
   logic [31:0]          retired_count;

   typedef struct {
      bit          complete;
      bit          has_dest;
      bit [AB-1:0] arch;
      bit [PB-1:0] tnew;
      bit [PB-1:0] told;
      bit          mis;
      bit          halt;
   } ent_t;

   ent_t        ents[N];
   int          compared   = 0;
   int          mismatched = 0;
   bit          m_halted;
   bit          m_flush;
   bit [31:0]   m_count;

   retire_unit #(.N(N), .PHYS_BITS(PB), .ARCH_BITS(AB)) dut (
      .clock(clock), .reset(reset), .rob_outputs(rob_outputs),
      .outputs_valid(outputs_valid), .num_retiring(num_retiring),
      .free_valid(free_valid), .free_reg(free_reg), .amt_we(amt_we),
      .amt_idx(amt_idx), .amt_reg(amt_reg), .flush(flush),
      .halted(halted), .retired_count(retired_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N*PKT_W-1:0] pack_all();
      logic [N*PKT_W-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         v[i*PKT_W +: PKT_W] = {ents[i].complete, ents[i].has_dest, ents[i].arch,
                                ents[i].tnew, ents[i].told, ents[i].mis, ents[i].halt};
      return v;
   endfunction

   task automatic set_ent(input int i, input bit c, input bit hd, input bit m, input bit h);
      ents[i].complete = c;
      ents[i].has_dest = hd;
      ents[i].arch     = AB'($urandom);
      ents[i].tnew     = PB'($urandom);
      ents[i].told     = PB'($urandom);
      ents[i].mis      = m;
      ents[i].halt     = h;
   endtask

   task automatic all_plain();
      for (int i = 0; i < N; i++) set_ent(i, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic rand_ents();
      for (int i = 0; i < N; i++)
         set_ent(i, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
   endtask

   function automatic bit [31:0] exp_cnt();
`ifdef RETIRE_PERF_CNT_EN
      return m_count;
`else
      return 32'd0;
`endif
   endfunction

   // One clock of operation: predict outputs from the current entries, then advance the model
   task automatic cycle(input int ov, input string tag);
      int     n;
      bit [N-1:0] exp_en;
      bit     next_flush;
      bit     next_halt;
      rob_outputs   = pack_all();
      outputs_valid = 2'(ov);
      #2;
      n = 0;
      if (!m_halted && !m_flush) begin
         while (n < ov && ents[n].complete) begin
            n++;
            if (ents[n-1].halt || ents[n-1].mis) break;
         end
      end
      exp_en = '0;
      for (int k = 0; k < n; k++) exp_en[k] = ents[k].has_dest;
      chk({tag, ":num_retiring"}, num_retiring, n);
      chk({tag, ":free_valid"}, free_valid, exp_en);
      chk({tag, ":amt_we"}, amt_we, exp_en);
      for (int k = 0; k < N; k++) begin
         if (exp_en[k]) begin
            chk({tag, ":free_reg"}, free_reg[k*PB +: PB], ents[k].told);
            chk({tag, ":amt_idx"}, amt_idx[k*AB +: AB], ents[k].arch);
            chk({tag, ":amt_reg"}, amt_reg[k*PB +: PB], ents[k].tnew);
         end
      end
      next_halt  = m_halted;
      next_flush = 1'b0;
      if (n > 0) begin
         if (ents[n-1].halt) next_halt = 1'b1;
         else if (ents[n-1].mis) next_flush = 1'b1;
      end
      m_count = m_count + 32'(n);
      @(posedge clock);
      #1;
      m_halted = next_halt;
      m_flush  = next_flush;
      chk({tag, ":flush"}, flush, m_flush);
      chk({tag, ":halted"}, halted, m_halted);
      chk({tag, ":retired_count"}, retired_count, exp_cnt());
   endtask

   // One clock with reset asserted while ready work is presented
   task automatic reset_cycle(input string tag);
      reset = 1'b1;
      all_plain();
      rob_outputs   = pack_all();
      outputs_valid = 2'd3;
      #2;
      chk({tag, ":num_retiring"}, num_retiring, 0);
      chk({tag, ":free_valid"}, free_valid, 0);
      chk({tag, ":amt_we"}, amt_we, 0);
      @(posedge clock);
      #1;
      m_halted = 1'b0;
      m_flush  = 1'b0;
      m_count  = 32'd0;
      chk({tag, ":flush"}, flush, 0);
      chk({tag, ":halted"}, halted, 0);
      chk({tag, ":retired_count"}, retired_count, 0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      rob_outputs = '0;
      outputs_valid = 2'd0;
      m_halted = 1'b0;
      m_flush = 1'b0;
      m_count = 32'd0;

      reset_cycle("rst0");

      all_plain();
      cycle(0, "ov0");
      all_plain();
      cycle(3, "all3");
      all_plain();
      ents[1].complete = 1'b0;
      cycle(3, "hole1");
      all_plain();
      ents[0].complete = 1'b0;
      cycle(3, "hole0");
      all_plain();
      cycle(2, "ov2");

      all_plain();
      ents[0].mis = 1'b1;
      cycle(3, "misp0");
      all_plain();
      cycle(3, "flush_cyc");
      all_plain();
      cycle(3, "after_flush");

      all_plain();
      ents[1].halt = 1'b1;
      cycle(3, "halt1");
      for (int k = 0; k < 10; k++) begin
         all_plain();
         cycle(3, "halted_idle");
      end
      reset_cycle("rst_halted");
      all_plain();
      cycle(3, "resume");

      all_plain();
      ents[0].has_dest = 1'b0;
      cycle(3, "nodest0");

      all_plain();
      ents[1].mis = 1'b1;
      cycle(3, "misp1");
      reset_cycle("rst_flush");
      all_plain();
      cycle(3, "post_rst_flush");

      all_plain();
      ents[0].mis  = 1'b1;
      ents[0].halt = 1'b1;
      cycle(3, "mis_halt");
      all_plain();
      cycle(3, "mis_halt_after");
      reset_cycle("rst_mh");

      for (int it = 0; it < 400; it++) begin
         if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 49) == 0) begin
            reset_cycle("rand_rst");
         end else begin
            rand_ents();
            cycle($urandom_range(0, 3), "rand");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
